// File: rtl/bit_serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop,
// LSB first, N+1 cycles per operation including the one-cycle DONE state.
module bit_serial_sub #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          brw_q, brw_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          bout_q, bout_d;

    logic          diff;
    logic          brw_nx;

    assign diff   = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        bout_d  = bout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = brw_nx;
                acc_d = {diff, acc_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                // Result is published only once the final bit is known.
                if (cnt_q == CW'(N - 1)) begin
                    dout_d  = {diff, acc_q[N-1:1]};
                    bout_d  = brw_nx;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
        end
    end

    assign d    = dout_q;
    assign bout = bout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
